// File: rtl/lcd_write_arbiter.sv
// HD44780-style LCD write sequencer: runs the power-on init commands, then
// shares the bus round-robin between two byte-write requesters.
module lcd_write_arbiter #(
  parameter int PWRUP_CYC     = 50_000,
  parameter int SETUP_CYC     = 4,
  parameter int EN_CYC        = 50_000,
  parameter int WAIT_CYC      = 50_000,
  parameter int LONG_WAIT_CYC = 100_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0,
  input  logic       rs0,
  input  logic [7:0] data0,
  output logic       ack0,
  input  logic       req1,
  input  logic       rs1,
  input  logic [7:0] data1,
  output logic       ack1,
  output logic       busy,
  output logic       init_done,
  output logic       lcd_en,
  output logic       lcd_rw,
  output logic       lcd_rs,
  output logic [7:0] lcd_data
);

  localparam int MAX_A   = (PWRUP_CYC > EN_CYC) ? PWRUP_CYC : EN_CYC;
  localparam int MAX_B   = (WAIT_CYC > LONG_WAIT_CYC) ? WAIT_CYC : LONG_WAIT_CYC;
  localparam int MAX_C   = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int MAX_CYC = (MAX_C > SETUP_CYC) ? MAX_C : SETUP_CYC;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  typedef enum logic [2:0] {
    S_PWRUP,
    S_IDLE,
    S_SETUP,
    S_PULSE,
    S_HOLD
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [1:0]         init_idx_q, init_idx_d;
  logic               in_init_q, in_init_d;
  logic               init_done_q, init_done_d;
  logic               last_q, last_d;
  logic               ack0_q, ack0_d;
  logic               ack1_q, ack1_d;
  logic               lcd_rs_q, lcd_rs_d;
  logic [7:0]         lcd_data_q, lcd_data_d;
  logic               gnt0, gnt1;
  logic               hold_end;

  function automatic logic [7:0] init_cmd(input logic [1:0] idx);
    case (idx)
      2'd0:    init_cmd = 8'h38;
      2'd1:    init_cmd = 8'h0E;
      2'd2:    init_cmd = 8'h01;
      default: init_cmd = 8'h06;
    endcase
  endfunction

  // Clear display and return home need the extended settle time.
  function automatic logic is_long_cmd(input logic rs, input logic [7:0] d);
    is_long_cmd = !rs && ((d == 8'h01) || (d == 8'h02));
  endfunction

  assign gnt0 = req0 && (!req1 || last_q);
  assign gnt1 = req1 && !gnt0;
  assign hold_end = is_long_cmd(lcd_rs_q, lcd_data_q) ?
                    (cnt_q == CNT_W'(LONG_WAIT_CYC - 1)) :
                    (cnt_q == CNT_W'(WAIT_CYC - 1));

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + 1'b1;
    init_idx_d  = init_idx_q;
    in_init_d   = in_init_q;
    init_done_d = init_done_q;
    last_d      = last_q;
    ack0_d      = 1'b0;
    ack1_d      = 1'b0;
    lcd_rs_d    = lcd_rs_q;
    lcd_data_d  = lcd_data_q;
    case (state_q)
      S_PWRUP: begin
        if (cnt_q == CNT_W'(PWRUP_CYC - 1)) begin
          state_d    = S_SETUP;
          init_idx_d = 2'd0;
          in_init_d  = 1'b1;
          lcd_rs_d   = 1'b0;
          lcd_data_d = init_cmd(2'd0);
        end
      end
      S_IDLE: begin
        cnt_d = '0;
        if (gnt0) begin
          state_d    = S_SETUP;
          ack0_d     = 1'b1;
          last_d     = 1'b0;
          lcd_rs_d   = rs0;
          lcd_data_d = data0;
        end else if (gnt1) begin
          state_d    = S_SETUP;
          ack1_d     = 1'b1;
          last_d     = 1'b1;
          lcd_rs_d   = rs1;
          lcd_data_d = data1;
        end
      end
      S_SETUP: begin
        if (cnt_q == CNT_W'(SETUP_CYC - 1)) state_d = S_PULSE;
      end
      S_PULSE: begin
        if (cnt_q == CNT_W'(EN_CYC - 1)) state_d = S_HOLD;
      end
      S_HOLD: begin
        if (hold_end) begin
          if (in_init_q && (init_idx_q != 2'd3)) begin
            state_d    = S_SETUP;
            init_idx_d = init_idx_q + 2'd1;
            lcd_rs_d   = 1'b0;
            lcd_data_d = init_cmd(init_idx_q + 2'd1);
          end else begin
            state_d = S_IDLE;
            if (in_init_q) begin
              in_init_d   = 1'b0;
              init_done_d = 1'b1;
            end
          end
        end
      end
      default: state_d = S_PWRUP;
    endcase
    // One shared counter: every phase starts counting from zero.
    if (state_d != state_q) cnt_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_PWRUP;
      cnt_q       <= '0;
      init_idx_q  <= 2'd0;
      in_init_q   <= 1'b0;
      init_done_q <= 1'b0;
      last_q      <= 1'b1;
      ack0_q      <= 1'b0;
      ack1_q      <= 1'b0;
      lcd_rs_q    <= 1'b0;
      lcd_data_q  <= 8'h00;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      init_idx_q  <= init_idx_d;
      in_init_q   <= in_init_d;
      init_done_q <= init_done_d;
      last_q      <= last_d;
      ack0_q      <= ack0_d;
      ack1_q      <= ack1_d;
      lcd_rs_q    <= lcd_rs_d;
      lcd_data_q  <= lcd_data_d;
    end
  end

  // EN is a pure decode of the state register so reset drops it at once.
  assign lcd_en    = (state_q == S_PULSE);
  assign lcd_rw    = 1'b0;
  assign lcd_rs    = lcd_rs_q;
  assign lcd_data  = lcd_data_q;
  assign busy      = (state_q != S_IDLE);
  assign init_done = init_done_q;
  assign ack0      = ack0_q;
  assign ack1      = ack1_q;

endmodule

// File: tb/tb_lcd_write_arbiter.sv
// Randomized directed bench for lcd_write_arbiter: an LCD bus monitor collects
// EN pulses and settle times and compares them with a rule-level model.
`timescale 1ns/1ps
module tb_lcd_write_arbiter;

  localparam int PWRUP = 10;
  localparam int SETUP = 2;
  localparam int EN    = 3;
  localparam int WAITC = 4;
  localparam int LONGC = 8;
  localparam logic [15:0] SKIP = 16'hFFFF;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req0 = 1'b0, rs0 = 1'b0, req1 = 1'b0, rs1 = 1'b0;
  logic [7:0] data0 = 8'h00, data1 = 8'h00;
  logic       ack0, ack1, busy, init_done, lcd_en, lcd_rw, lcd_rs;
  logic [7:0] lcd_data;

  lcd_write_arbiter #(
    .PWRUP_CYC(PWRUP), .SETUP_CYC(SETUP), .EN_CYC(EN),
    .WAIT_CYC(WAITC), .LONG_WAIT_CYC(LONGC)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .rs0(rs0), .data0(data0), .ack0(ack0),
    .req1(req1), .rs1(rs1), .data1(data1), .ack1(ack1),
    .busy(busy), .init_done(init_done),
    .lcd_en(lcd_en), .lcd_rw(lcd_rw), .lcd_rs(lcd_rs), .lcd_data(lcd_data)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        rs;
    logic [7:0]  data;
    logic [15:0] hi;
    logic [15:0] lo;
    logic [15:0] hold;
  } pulse_t;

  pulse_t      pulse_q[$];
  pulse_t      exp_q[$];
  logic [15:0] hold_q[$];

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;
  int ack_total = 0;
  int last_grant = 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int exp_wait(input logic rs, input logic [7:0] d);
    return (!rs && (d == 8'h01 || d == 8'h02)) ? LONGC : WAITC;
  endfunction

  // Bus monitor: records each EN pulse with its payload, width and the low
  // time before it, and the low time between an EN fall and busy dropping.
  logic        en_prev = 1'b0, busy_prev = 1'b1, ack_prev = 1'b0;
  logic        cur_rs = 1'b0;
  logic [7:0]  cur_data = 8'h00;
  logic [15:0] lo_cnt = 0, hi_cnt = 0, hold_cnt = 0, cur_lo = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      en_prev = 1'b0; busy_prev = 1'b1; ack_prev = 1'b0;
      lo_cnt = 0; hi_cnt = 0; hold_cnt = 0;
    end else begin
      if (lcd_en) begin
        if (!en_prev) begin
          cur_rs = lcd_rs; cur_data = lcd_data; cur_lo = lo_cnt; hi_cnt = 0;
        end else begin
          check("pulse_payload_stable", {lcd_rs, lcd_data}, {cur_rs, cur_data});
        end
        hi_cnt++;
      end else begin
        if (en_prev) begin
          pulse_q.push_back('{cur_rs, cur_data, hi_cnt, cur_lo, 16'h0});
          lo_cnt = 0; hold_cnt = 0;
        end
        lo_cnt++;
        if (busy) hold_cnt++;
      end
      if (!busy && busy_prev) hold_q.push_back(hold_cnt);
      if (ack0 || ack1) begin
        ack_total++;
        check("ack_after_init", init_done, 1);
        check("ack_single_cycle", ack_prev, 0);
        check("ack_one_hot", ack0 & ack1, 0);
      end
      check("lcd_rw_zero", lcd_rw, 0);
      en_prev = lcd_en; busy_prev = busy; ack_prev = ack0 | ack1;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check(tag, {lcd_en, lcd_rw, lcd_rs, lcd_data, ack0, ack1, busy, init_done},
          {1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0});
  endtask

  task automatic check_init(input int ack_base);
    logic [7:0] cmds [4];
    pulse_t     o;
    int         n;
    int         lo_exp;
    logic [15:0] h;
    cmds[0] = 8'h38; cmds[1] = 8'h0E; cmds[2] = 8'h01; cmds[3] = 8'h06;
    n = 0;
    while (!init_done && n < 500) begin tick(); n++; end
    check("init_done_rise", init_done, 1);
    check("init_no_ack", ack_total, ack_base);
    check("init_pulse_count", pulse_q.size(), 4);
    for (int k = 0; k < 4; k++) begin
      if (pulse_q.size() > 0) begin
        o = pulse_q.pop_front();
        lo_exp = (k == 0) ? (PWRUP + SETUP) : (exp_wait(1'b0, cmds[k-1]) + SETUP);
        check("init_rs", o.rs, 0);
        check("init_data", o.data, cmds[k]);
        check("init_en_width", o.hi, EN);
        check("init_gap", o.lo, lo_exp);
      end
    end
    @(negedge clk); #1;
    check("init_hold_count", hold_q.size(), 1);
    if (hold_q.size() > 0) begin
      h = hold_q.pop_front();
      check("init_last_hold", h, exp_wait(1'b0, 8'h06));
    end
  endtask

  task automatic compare_writes();
    pulse_t e, o;
    logic [15:0] h;
    check("write_pulse_count", pulse_q.size(), exp_q.size());
    check("write_hold_count", hold_q.size(), exp_q.size());
    while (exp_q.size() > 0 && pulse_q.size() > 0 && hold_q.size() > 0) begin
      e = exp_q.pop_front();
      o = pulse_q.pop_front();
      h = hold_q.pop_front();
      check("write_rs", o.rs, e.rs);
      check("write_data", o.data, e.data);
      check("write_en_width", o.hi, e.hi);
      if (e.lo != SKIP) check("write_gap", o.lo, e.lo);
      check("write_hold", h, e.hold);
    end
    exp_q.delete(); pulse_q.delete(); hold_q.delete();
  endtask

  task automatic wait_busy_low(input logic rs, input logic [7:0] d, input int drop_who);
    int b = 0;
    while (busy && b < 300) begin
      tick(); b++;
      if (b == 1) begin
        if (drop_who == 0) req0 = 1'b0;
        else req1 = 1'b0;
      end
    end
    check("busy_len_after_grant", b, SETUP + EN + exp_wait(rs, d));
    @(negedge clk); #1;
    compare_writes();
  endtask

  task automatic do_write(input int who, input logic rs, input logic [7:0] d);
    int n = 0;
    tick();
    if (who == 0) begin req0 = 1'b1; rs0 = rs; data0 = d; end
    else begin req1 = 1'b1; rs1 = rs; data1 = d; end
    while (!(ack0 || ack1) && n < 300) begin tick(); n++; end
    check("grant_seen", ack0 | ack1, 1);
    check("grant_who", ack1 ? 1 : 0, who);
    last_grant = who;
    exp_q.push_back('{rs, d, EN[15:0], SKIP, exp_wait(rs, d)});
    wait_busy_low(rs, d, who);
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int base;
    int exp_who, got;
    logic       r;
    logic [7:0] d;

    // Scenario 1: init sequence with requester 0 already waiting.
    req0 = 1'b1; rs0 = 1'b1; data0 = 8'h41;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset_state");
    rst_n = 1'b1;
    check_init(0);
    n = 0;
    while (!(ack0 || ack1) && n < 50) begin tick(); n++; end
    check("first_grant_ack0", {ack0, ack1}, 2'b10);
    last_grant = 0;
    exp_q.push_back('{1'b1, 8'h41, EN[15:0], 16'(1 + SETUP + exp_wait(1'b0, 8'h06)), WAITC[15:0]});
    wait_busy_low(1'b1, 8'h41, 0);

    // Scenario 2: requester 1 alone, then a few random single writes.
    do_write(1, 1'b1, 8'h53);
    for (int i = 0; i < 4; i++) begin
      do_write(int'($urandom_range(0, 1)), 1'b1, 8'($urandom));
    end

    // Scenario 3: both requesters held high; grants must alternate.
    tick();
    base = ack_total;
    req0 = 1'b1; rs0 = 1'($urandom); data0 = 8'($urandom);
    req1 = 1'b1; rs1 = 1'($urandom); data1 = 8'($urandom);
    for (int k = 0; k < 4; k++) begin
      n = 0;
      while (!(ack0 || ack1) && n < 300) begin tick(); n++; end
      exp_who = (last_grant == 1) ? 0 : 1;
      got = ack1 ? 1 : 0;
      check("tie_grant_order", got, exp_who);
      r = (exp_who == 0) ? rs0 : rs1;
      d = (exp_who == 0) ? data0 : data1;
      exp_q.push_back('{r, d, EN[15:0], SKIP, exp_wait(r, d)});
      last_grant = exp_who;
      tick();
      if (k == 3) begin
        req0 = 1'b0; req1 = 1'b0;
      end else if (exp_who == 0) begin
        rs0 = 1'($urandom); data0 = 8'($urandom_range(0, 3));
      end else begin
        rs1 = 1'($urandom); data1 = 8'($urandom_range(0, 3));
      end
    end
    n = 0;
    while (busy && n < 300) begin tick(); n++; end
    @(negedge clk); #1;
    check("tie_ack_total", ack_total - base, 4);
    compare_writes();

    // Scenario 4: settle-time selection, directed and random.
    do_write(0, 1'b0, 8'h02);
    do_write(1, 1'b0, 8'h80);
    do_write(0, 1'b1, 8'h01);
    do_write(1, 1'b0, 8'h01);
    for (int i = 0; i < 6; i++) begin
      r = 1'($urandom);
      d = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 3)) : 8'($urandom);
      do_write(int'($urandom_range(0, 1)), r, d);
    end

    // Scenario 5: reset asserted in the second cycle of an EN pulse.
    tick();
    req0 = 1'b1; rs0 = 1'b1; data0 = 8'($urandom);
    n = 0;
    while (!lcd_en && n < 300) begin
      tick(); n++;
      if (ack0) req0 = 1'b0;
    end
    req0 = 1'b0;
    check("pulse_reached", lcd_en, 1);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("async_en_drop", lcd_en, 0);
    check_reset_outputs("async_reset_state");
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("held_reset_state");
    pulse_q.delete(); hold_q.delete(); exp_q.delete();
    last_grant = 1;
    base = ack_total;
    rst_n = 1'b1;

    // Scenario 6: a request withdrawn before init completes is never served.
    repeat (3) tick();
    req0 = 1'b1; rs0 = 1'($urandom); data0 = 8'($urandom);
    repeat (4) tick();
    req0 = 1'b0;
    check_init(base);
    repeat (30) tick();
    check("no_extra_pulse", pulse_q.size(), 0);
    check("withdrawn_no_ack", ack_total, base);
    check("idle_after_init", busy, 0);

    // Tie after reset: requester 0 wins the first tie again.
    tick();
    req0 = 1'b1; rs0 = 1'b1; data0 = 8'($urandom);
    req1 = 1'b1; rs1 = 1'b1; data1 = 8'($urandom);
    n = 0;
    while (!(ack0 || ack1) && n < 50) begin tick(); n++; end
    check("post_reset_tie", {ack0, ack1}, 2'b10);
    tick();
    req0 = 1'b0; req1 = 1'b0;
    n = 0;
    while (busy && n < 300) begin tick(); n++; end
    @(negedge clk); #1;
    pulse_q.delete(); hold_q.delete();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
